dot_product_stream: RTL and testbench

Sequential, parametrised successor to the combinational `dot_product`. It computes the dot product of two vectors streamed in `LANES` elements per beat over a valid/ready interface, for lengths up to `MAX_LEN`. Signed and unsigned modes are selectable per job, as are wrap and saturate modes. The block sits between the vector source (memory reader or DMA) and the result consumer, and holds one job at a time.

---
 rtl/dot_product_pkg.sv | 38 +++
 rtl/dot_product_lane_tree.sv | 66 ++++++
 rtl/dot_product_stream.sv | 197 +++++++++++++++++++
 tb/tb_dot_product_stream.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// rtl/dot_product_pkg.sv - shared types and width/bound helpers for the streaming dot product
package dot_product_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Saturation bounds are built in a fixed wide type so they can be compared
  // against any sign/zero-extended accumulator without per-instance functions.
  localparam int BOUND_W = 128;
  typedef logic [BOUND_W-1:0] bound_t;

  function automatic int acc_width(input int data_w, input int max_len);
    return 2 * data_w + $clog2(max_len);
  endfunction

  function automatic bound_t sat_hi(input int data_w, input logic is_signed);
    bound_t one;
    one = bound_t'(1);
    if (is_signed) begin
      return (one << (data_w - 1)) - one;
    end
    return (one << data_w) - one;
  endfunction

  function automatic bound_t sat_lo(input int data_w, input logic is_signed);
    bound_t one;
    one = bound_t'(1);
    if (is_signed) begin
      return ~((one << (data_w - 1)) - one);
    end
    return '0;
  endfunction

endpackage

// File: rtl/dot_product_lane_tree.sv
// rtl/dot_product_lane_tree.sv - per-lane multipliers, lane masking and registered adder tree
module dot_product_lane_tree #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int ACC_W  = 68
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     beat_valid_i,
  input  logic                     signed_i,
  input  logic [LANES-1:0]         lane_mask_i,
  input  logic [DATA_W*LANES-1:0]  a_i,
  input  logic [DATA_W*LANES-1:0]  b_i,
  output logic [ACC_W-1:0]         sum_o,
  output logic                     sum_valid_o
);

  logic [ACC_W-1:0] sum_d;
  logic [ACC_W-1:0] sum_q;
  logic             valid_q;

  // One 2*DATA_W multiply per lane covers both modes: operands are extended
  // according to the mode, so the low 2*DATA_W bits are exact either way.
  always_comb begin
    logic [2*DATA_W-1:0] ea;
    logic [2*DATA_W-1:0] eb;
    logic [2*DATA_W-1:0] prod;
    ea    = '0;
    eb    = '0;
    prod  = '0;
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (signed_i) begin
        ea = {{DATA_W{a_i[DATA_W*i+DATA_W-1]}}, a_i[DATA_W*i +: DATA_W]};
        eb = {{DATA_W{b_i[DATA_W*i+DATA_W-1]}}, b_i[DATA_W*i +: DATA_W]};
      end else begin
        ea = {{DATA_W{1'b0}}, a_i[DATA_W*i +: DATA_W]};
        eb = {{DATA_W{1'b0}}, b_i[DATA_W*i +: DATA_W]};
      end
      prod = ea * eb;
      if (lane_mask_i[i]) begin
        if (signed_i) begin
          sum_d = sum_d + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end else begin
          sum_d = sum_d + {{(ACC_W-2*DATA_W){1'b0}}, prod};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= beat_valid_i;
      if (beat_valid_i) begin
        sum_q <= sum_d;
      end
    end
  end

  assign sum_o       = sum_q;
  assign sum_valid_o = valid_q;

endmodule

// File: rtl/dot_product_stream.sv
// rtl/dot_product_stream.sv - streaming dot product: job FSM, accumulator and result formatting
module dot_product_stream
  import dot_product_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LANES   = 4,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [LEN_W-1:0]         len_i,
  input  logic                     signed_mode_i,
  input  logic                     sat_mode_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_W*LANES-1:0]  in_a_i,
  input  logic [DATA_W*LANES-1:0]  in_b_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_W-1:0]        out_result_o,
  output logic                     out_overflow_o,
  output logic                     busy_o
);

  localparam int ACC_W = acc_width(DATA_W, MAX_LEN);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   beats_left_q, beats_left_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               signed_q, signed_d;
  logic               sat_q, sat_d;
  logic               drain_q, drain_d;
  logic               in_ready_q, in_ready_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               ovf_q, ovf_d;

  logic [LEN_W-1:0]   len_c;
  logic [LEN_W-1:0]   beats_init;
  logic [LEN_W-1:0]   rem_init;
  logic               accept;
  logic               last_beat;
  logic [LANES-1:0]   lane_mask;
  logic [ACC_W-1:0]   beat_sum;
  logic               beat_sum_vld;

  bound_t             acc_ext;
  bound_t             hi_b;
  bound_t             lo_b;
  logic               over_hi;
  logic               over_lo;
  logic [DATA_W-1:0]  fmt_result;

  assign len_c      = (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;
  assign beats_init = LEN_W'((int'(len_c) + LANES - 1) / LANES);
  assign rem_init   = LEN_W'(int'(len_c) % LANES);
  assign accept     = in_valid_i && in_ready_q;
  assign last_beat  = (beats_left_q == LEN_W'(1));

  // Only the final beat of a job whose length is not a lane multiple is partial.
  always_comb begin
    lane_mask = '1;
    for (int i = 0; i < LANES; i++) begin
      if (last_beat && (rem_q != '0) && (i >= int'(rem_q))) begin
        lane_mask[i] = 1'b0;
      end
    end
  end

  dot_product_lane_tree #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .ACC_W  (ACC_W)
  ) u_lane_tree (
    .clk          (clk),
    .rst_n        (rst_n),
    .beat_valid_i (accept),
    .signed_i     (signed_q),
    .lane_mask_i  (lane_mask),
    .a_i          (in_a_i),
    .b_i          (in_b_i),
    .sum_o        (beat_sum),
    .sum_valid_o  (beat_sum_vld)
  );

  // Unsigned accumulators can use the top bit as magnitude, so extension follows the job mode.
  always_comb begin
    if (signed_q) begin
      acc_ext = {{(BOUND_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    end else begin
      acc_ext = {{(BOUND_W-ACC_W){1'b0}}, acc_q};
    end
    hi_b    = sat_hi(DATA_W, signed_q);
    lo_b    = sat_lo(DATA_W, signed_q);
    over_hi = $signed(acc_ext) > $signed(hi_b);
    over_lo = $signed(acc_ext) < $signed(lo_b);
    if (sat_q && over_hi) begin
      fmt_result = hi_b[DATA_W-1:0];
    end else if (sat_q && over_lo) begin
      fmt_result = lo_b[DATA_W-1:0];
    end else begin
      fmt_result = acc_q[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    rem_d        = rem_q;
    signed_d     = signed_q;
    sat_d        = sat_q;
    drain_d      = drain_q;
    acc_d        = acc_q;
    result_d     = result_q;
    ovf_d        = ovf_q;

    if (beat_sum_vld) begin
      acc_d = acc_q + beat_sum;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          acc_d        = '0;
          signed_d     = signed_mode_i;
          sat_d        = sat_mode_i;
          beats_left_d = beats_init;
          rem_d        = rem_init;
          drain_d      = 1'b0;
          state_d      = (len_c == '0) ? ST_DRAIN : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          beats_left_d = beats_left_q - LEN_W'(1);
          if (last_beat) begin
            drain_d = 1'b0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // First cycle lets the last beat_sum reach the accumulator; second formats it.
        if (!drain_q) begin
          drain_d = 1'b1;
        end else begin
          result_d = fmt_result;
          ovf_d    = over_hi || over_lo;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      beats_left_q <= '0;
      rem_q        <= '0;
      signed_q     <= 1'b0;
      sat_q        <= 1'b0;
      drain_q      <= 1'b0;
      in_ready_q   <= 1'b0;
      acc_q        <= '0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      rem_q        <= rem_d;
      signed_q     <= signed_d;
      sat_q        <= sat_d;
      drain_q      <= drain_d;
      in_ready_q   <= in_ready_d;
      acc_q        <= acc_d;
      result_q     <= result_d;
      ovf_q        <= ovf_d;
    end
  end

  assign in_ready_o     = in_ready_q;
  assign out_valid_o    = (state_q == ST_DONE);
  assign busy_o         = (state_q != ST_IDLE);
  assign out_result_o   = result_q;
  assign out_overflow_o = ovf_q;

endmodule

// File: tb/tb_dot_product_stream.sv
// tb/tb_dot_product_stream.sv - directed self-checking bench for dot_product_stream
module tb_dot_product_stream;

  localparam int DATA_W  = 32;
  localparam int LANES   = 4;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic [LEN_W-1:0]        len_in;
  logic                    signed_mode;
  logic                    sat_mode;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W*LANES-1:0] in_a;
  logic [DATA_W*LANES-1:0] in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_result;
  logic                    out_overflow;
  logic                    busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] va [16];
  logic [31:0] vb [16];
  logic [31:0] fill;

  dot_product_stream #(
    .DATA_W  (DATA_W),
    .LANES   (LANES),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .len_i          (len_in),
    .signed_mode_i  (signed_mode),
    .sat_mode_i     (sat_mode),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_a_i         (in_a),
    .in_b_i         (in_b),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_result_o   (out_result),
    .out_overflow_o (out_overflow),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_seq();
    for (int i = 0; i < 16; i++) begin
      va[i] = 32'(i + 1);
      vb[i] = 32'(2 * (i + 1));
    end
  endtask

  task automatic set_const(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 16; i++) begin
      va[i] = a;
      vb[i] = b;
    end
  endtask

  task automatic run_job(input string tag, input int len, input bit sgn, input bit sat,
                         input int gap, input int hold,
                         input logic [31:0] exp_res, input bit exp_ovf);
    int len_c;
    int nbeats;
    int w;
    int e;
    logic [127:0] pa;
    logic [127:0] pb;
    len_c  = (len > MAX_LEN) ? MAX_LEN : len;
    nbeats = (len_c + LANES - 1) / LANES;
    start       = 1'b1;
    len_in      = LEN_W'(len);
    signed_mode = sgn;
    sat_mode    = sat;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      for (int l = 0; l < LANES; l++) begin
        e = b * LANES + l;
        pa[32*l +: 32] = (e < len_c) ? va[e] : fill;
        pb[32*l +: 32] = (e < len_c) ? vb[e] : fill;
      end
      in_a     = pa;
      in_b     = pb;
      in_valid = 1'b1;
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      if (b != nbeats - 1) begin
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
    end
    check({tag, ".ready_low"}, 64'(in_ready), 64'd0);
    check({tag, ".busy"}, 64'(busy), 64'd1);
    check({tag, ".lat0"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, ".lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, ".lat2"}, 64'(out_valid), 64'd1);
    check({tag, ".result"}, 64'(out_result), 64'(exp_res));
    check({tag, ".overflow"}, 64'(out_overflow), 64'(exp_ovf));
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        start  = 1'b1;
        len_in = LEN_W'(16);
      end
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".hold_result"}, 64'(out_result), 64'(exp_res));
      check({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    len_in    = LEN_W'(16);
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    check({tag, ".valid_fall"}, 64'(out_valid), 64'd0);
    check({tag, ".idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    len_in      = '0;
    signed_mode = 1'b0;
    sat_mode    = 1'b0;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    out_ready   = 1'b0;
    fill        = '0;
    #12;
    check("rst.in_ready", 64'(in_ready), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_result", 64'(out_result), 64'd0);
    check("rst.overflow", 64'(out_overflow), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_seq();
    fill = 32'h0;
    run_job("u16", 16, 1'b0, 1'b0, 0, 0, 32'd2992, 1'b0);
    fill = 32'hFFFF_FFFF;
    run_job("u10", 10, 1'b0, 1'b0, 0, 0, 32'd770, 1'b0);
    run_job("u20_clamp", 20, 1'b0, 1'b0, 0, 0, 32'd2992, 1'b0);

    set_const(32'hFFFF_FFFD, 32'd5);
    fill = 32'h0;
    run_job("s4_wrap", 4, 1'b1, 1'b0, 0, 0, 32'hFFFF_FFC4, 1'b0);
    run_job("len0", 0, 1'b0, 1'b0, 0, 0, 32'd0, 1'b0);

    set_const(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    fill = 32'hFFFF_FFFF;
    run_job("u2_wrap", 2, 1'b0, 1'b0, 0, 0, 32'd2, 1'b1);
    run_job("u2_sat", 2, 1'b0, 1'b1, 0, 0, 32'hFFFF_FFFF, 1'b1);

    set_const(32'h8000_0000, 32'h7FFF_FFFF);
    fill = 32'h7FFF_FFFF;
    run_job("s2_sat_neg", 2, 1'b1, 1'b1, 0, 0, 32'h8000_0000, 1'b1);

    set_seq();
    fill = 32'h0;
    run_job("backpressure", 16, 1'b0, 1'b0, 0, 5, 32'd2992, 1'b0);
    run_job("gaps", 16, 1'b0, 1'b0, 3, 0, 32'd2992, 1'b0);

    start  = 1'b1;
    len_in = LEN_W'(16);
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int l = 0; l < LANES; l++) begin
        in_a[32*l +: 32] = va[b*LANES + l];
        in_b[32*l +: 32] = vb[b*LANES + l];
      end
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("abort.in_ready", 64'(in_ready), 64'd0);
    check("abort.out_valid", 64'(out_valid), 64'd0);
    check("abort.out_result", 64'(out_result), 64'd0);
    check("abort.overflow", 64'(out_overflow), 64'd0);
    check("abort.busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort.no_result", 64'(out_valid), 64'd0);
    run_job("post_reset", 16, 1'b0, 1'b0, 0, 0, 32'd2992, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
